// File: rtl/slc3_button_ctrl.sv
// SLC-3 front-panel key receiver: sync, debounce, press pulses and
// the CPU pause/continue handshake.

module slc3_key_deb #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic stable,
   output logic fall,
   output logic rise,
   output logic pulse
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic                   s;
   logic                   differ;
   logic                   flip;

   always_comb begin
      s      = sync[SYNC_STAGES-1];
      differ = (s != stable);
      flip   = differ && (cnt == LAST);
      fall   = flip && !s;
      rise   = flip && s;
   end

   // Counter clears whenever s agrees with stable, so it tops out at LAST
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync   <= '1;
         stable <= 1'b1;
         cnt    <= '0;
         pulse  <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], key_n};
         pulse <= fall;
         if (!differ || flip)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         if (flip)
            stable <= s;
      end
   end

endmodule

module slc3_button_ctrl #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int CNT_W           = 16
) (
   input  logic Clk,
   input  logic Reset,
   input  logic Run_n,
   input  logic Continue_n,
   input  logic Pause_req,
   output logic Pause_ack,
   output logic Paused,
   output logic Run_pulse,
   output logic Continue_pulse,
   output logic Run_level,
   output logic Continue_level
);

   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] WAIT_PRESS   = 2'd1;
   localparam logic [1:0] WAIT_RELEASE = 2'd2;
   localparam logic [1:0] ACK          = 2'd3;

   logic       run_t, run_fall, run_rise;
   logic       cont_t, cont_fall, cont_rise;
   logic [1:0] state, state_nx;

   slc3_key_deb #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_run (
      .clk   (Clk),
      .rst_n (Reset),
      .key_n (Run_n),
      .stable(run_t),
      .fall  (run_fall),
      .rise  (run_rise),
      .pulse (Run_pulse)
   );

   slc3_key_deb #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_cont (
      .clk   (Clk),
      .rst_n (Reset),
      .key_n (Continue_n),
      .stable(cont_t),
      .fall  (cont_fall),
      .rise  (cont_rise),
      .pulse (Continue_pulse)
   );

   // Run is a CPU reset, so it beats Continue and any pending pause
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (Pause_req)
               state_nx = WAIT_PRESS;
         WAIT_PRESS:
            if (run_fall || !Pause_req)
               state_nx = IDLE;
            else if (cont_fall)
               state_nx = WAIT_RELEASE;
         WAIT_RELEASE:
            if (run_fall || !Pause_req)
               state_nx = IDLE;
            else if (cont_rise)
               state_nx = ACK;
         ACK:
            if (run_fall || !Pause_req)
               state_nx = IDLE;
         default:
            state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   logic unused_run_rise;
   assign unused_run_rise = run_rise;

   assign Pause_ack      = (state == ACK);
   assign Paused         = (state != IDLE);
   assign Run_level      = ~run_t;
   assign Continue_level = ~cont_t;

endmodule
